// File: rtl/ps_hp_pkg.sv
// Shared definitions for the pshare branch predictor (ps_hp_param).
// Holds the init/run state encoding, a constant-evaluable clog2, a max helper
// and the PHT counter clear value (weakly not-taken).
package ps_hp_pkg;

    // INIT sweeps the tables clear; RUN predicts and trains until the next reset.
    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } ps_state_e;

    // Ceiling log2, usable in localparam expressions.
    function automatic int ps_clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result++;
        end
        return result;
    endfunction

    // Largest of three depths; sizes the shared clear sweep.
    function automatic int ps_max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) begin
            m = b;
        end
        if (c > m) begin
            m = c;
        end
        return m;
    endfunction

    // Counter clear value: one below the taken threshold (weakly not-taken).
    function automatic int ps_ctr_init(input int ctr_bits);
        return (1 << (ctr_bits - 1)) - 1;
    endfunction

endpackage

// File: rtl/ps_sat_ctr.sv
// Saturating up/down counter step used by the PHT training path.
// Pure combinational: returns the next counter value for one update.
module ps_sat_ctr #(
    parameter int CTR_BITS = 2
) (
    input  logic [CTR_BITS-1:0] ctr,
    input  logic                inc,
    input  logic                en,
    output logic [CTR_BITS-1:0] ctr_nxt
);

    localparam logic [CTR_BITS-1:0] CTR_MAX = '1;
    localparam logic [CTR_BITS-1:0] CTR_MIN = '0;

    // Step toward the resolved direction, holding at either rail.
    always_comb begin
        ctr_nxt = ctr;
        if (en) begin
            if (inc) begin
                if (ctr != CTR_MAX) begin
                    ctr_nxt = ctr + CTR_BITS'(1);
                end
            end else begin
                if (ctr != CTR_MIN) begin
                    ctr_nxt = ctr - CTR_BITS'(1);
                end
            end
        end
    end

endmodule

// File: rtl/ps_hp_param.sv
// pshare branch predictor: per-PC local history (BHT) XOR PC selects a PHT
// saturating counter; a BTB supplies the predicted offset.
// Fetch lookups are combinational from current table state; exe updates are
// written at the clock edge, so a same-cycle fetch sees pre-update values.
// After reset an INIT sweep clears every table, one index per cycle.
// Optional macro PS_HP_BTB_TAG_EN: store a PC tag per BTB entry and require a
// tag match for a hit; without it a valid entry hits on index alone.
module ps_hp_param
    import ps_hp_pkg::*;
#(
    parameter int BHT_ENTRIES     = 256,
    parameter int HIST_LEN        = 8,
    parameter int CTR_BITS        = 2,
    parameter int BTB_ENTRIES     = 256,
    parameter int INSTR_SIZE_BYTE = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [INSTR_SIZE_BYTE*8-1:0] in_fetch_pc,
    input  logic                         in_fetch_nop,
    input  logic [INSTR_SIZE_BYTE*8-1:0] in_exe_pc,
    input  logic                         in_exe_nop,
    input  logic                         in_exe_branch_taken,
    input  logic [INSTR_SIZE_BYTE*8-1:0] in_exe_branch_offset,
    output logic [INSTR_SIZE_BYTE*8-1:0] out_pc_offset,
    output logic                         out_fetch_branch_taken,
    output logic                         out_btb_hit,
    output logic                         out_init_done
);

    localparam int W      = INSTR_SIZE_BYTE * 8;
    localparam int BHT_IW = ps_clog2(BHT_ENTRIES);
    localparam int BTB_IW = ps_clog2(BTB_ENTRIES);
    localparam int PHT_D  = 1 << HIST_LEN;
    localparam int MAXD   = ps_max3(BHT_ENTRIES, PHT_D, BTB_ENTRIES);
    localparam int CLR_W  = ps_clog2(MAXD);

    localparam logic [CLR_W-1:0]    CLR_LAST = CLR_W'(MAXD - 1);
    localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'(ps_ctr_init(CTR_BITS));

`ifdef PS_HP_BTB_TAG_EN
    localparam int TAG_W = W - BTB_IW - 2;
`endif

    // ---------------------------------------------------------------
    // Control: init sweep state, clear index, init-done flag
    // ---------------------------------------------------------------
    ps_state_e        state_q, state_d;
    logic [CLR_W-1:0] clr_idx_q, clr_idx_d;
    logic             init_done_q, init_done_d;

    // ---------------------------------------------------------------
    // Tables (no reset: the INIT sweep is what clears them)
    // ---------------------------------------------------------------
    logic [HIST_LEN-1:0] bht_q     [BHT_ENTRIES];
    logic [HIST_LEN-1:0] bht_d     [BHT_ENTRIES];
    logic [CTR_BITS-1:0] pht_q     [PHT_D];
    logic [CTR_BITS-1:0] pht_d     [PHT_D];
    logic                btb_val_q [BTB_ENTRIES];
    logic                btb_val_d [BTB_ENTRIES];
    logic [W-1:0]        btb_off_q [BTB_ENTRIES];
    logic [W-1:0]        btb_off_d [BTB_ENTRIES];
`ifdef PS_HP_BTB_TAG_EN
    logic [TAG_W-1:0]    btb_tag_q [BTB_ENTRIES];
    logic [TAG_W-1:0]    btb_tag_d [BTB_ENTRIES];
`endif

    // ---------------------------------------------------------------
    // Fetch lookup path
    // ---------------------------------------------------------------
    logic [BHT_IW-1:0]   f_bht_idx;
    logic [HIST_LEN-1:0] f_pht_idx;
    logic [BTB_IW-1:0]   f_btb_idx;
    logic [CTR_BITS-1:0] f_ctr;
    logic                f_tag_ok;
    logic                f_hit;
    logic                f_taken;

    assign f_bht_idx = in_fetch_pc[BHT_IW+1:2];
    assign f_pht_idx = bht_q[f_bht_idx] ^ in_fetch_pc[HIST_LEN+1:2];
    assign f_btb_idx = in_fetch_pc[BTB_IW+1:2];
    assign f_ctr     = pht_q[f_pht_idx];

`ifdef PS_HP_BTB_TAG_EN
    assign f_tag_ok = (btb_tag_q[f_btb_idx] == in_fetch_pc[W-1:BTB_IW+2]);
`else
    assign f_tag_ok = 1'b1;
`endif

    // Hit and taken are forced low until the tables are known clean.
    assign f_hit   = init_done_q && btb_val_q[f_btb_idx] && f_tag_ok;
    assign f_taken = !in_fetch_nop && f_hit && f_ctr[CTR_BITS-1];

    assign out_btb_hit            = f_hit;
    assign out_fetch_branch_taken = f_taken;
    assign out_pc_offset          = f_taken ? btb_off_q[f_btb_idx] : '0;
    assign out_init_done          = init_done_q;

    // ---------------------------------------------------------------
    // Exe update path (indices from pre-update history)
    // ---------------------------------------------------------------
    logic [BHT_IW-1:0]   e_bht_idx;
    logic [HIST_LEN-1:0] e_hist;
    logic [HIST_LEN-1:0] e_pht_idx;
    logic [BTB_IW-1:0]   e_btb_idx;
    logic [CTR_BITS-1:0] e_ctr;
    logic [CTR_BITS-1:0] e_ctr_nxt;
    logic                e_upd;

    assign e_bht_idx = in_exe_pc[BHT_IW+1:2];
    assign e_hist    = bht_q[e_bht_idx];
    assign e_pht_idx = e_hist ^ in_exe_pc[HIST_LEN+1:2];
    assign e_btb_idx = in_exe_pc[BTB_IW+1:2];
    assign e_ctr     = pht_q[e_pht_idx];
    // Updates arriving during INIT are simply dropped.
    assign e_upd     = !in_exe_nop && init_done_q;

    ps_sat_ctr #(
        .CTR_BITS (CTR_BITS)
    ) u_sat_ctr (
        .ctr     (e_ctr),
        .inc     (in_exe_branch_taken),
        .en      (e_upd),
        .ctr_nxt (e_ctr_nxt)
    );

    // PC bits outside the index/tag fields are intentionally ignored.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{in_fetch_pc, in_exe_pc};

    // Next-state for the init sweep: count indices, then settle in RUN.
    always_comb begin
        state_d     = state_q;
        clr_idx_d   = clr_idx_q;
        init_done_d = init_done_q;
        case (state_q)
            ST_INIT: begin
                if (clr_idx_q == CLR_LAST) begin
                    state_d     = ST_RUN;
                    init_done_d = 1'b1;
                    clr_idx_d   = '0;
                end else begin
                    clr_idx_d = clr_idx_q + CLR_W'(1);
                end
            end
            ST_RUN: begin
                state_d     = ST_RUN;
                init_done_d = 1'b1;
            end
            default: begin
                state_d     = ST_INIT;
                init_done_d = 1'b0;
                clr_idx_d   = '0;
            end
        endcase
    end

    // Control registers; reset restarts the sweep from index 0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_INIT;
            clr_idx_q   <= '0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            clr_idx_q   <= clr_idx_d;
            init_done_q <= init_done_d;
        end
    end

    // Table next-state: one clear per cycle in INIT, one training write in RUN.
    always_comb begin
        bht_d     = bht_q;
        pht_d     = pht_q;
        btb_val_d = btb_val_q;
        btb_off_d = btb_off_q;
`ifdef PS_HP_BTB_TAG_EN
        btb_tag_d = btb_tag_q;
`endif
        if (state_q == ST_INIT) begin
            // Sweep index beyond a smaller table's depth is ignored for it.
            if (int'(clr_idx_q) < BHT_ENTRIES) begin
                bht_d[clr_idx_q[BHT_IW-1:0]] = '0;
            end
            if (int'(clr_idx_q) < PHT_D) begin
                pht_d[clr_idx_q[HIST_LEN-1:0]] = CTR_INIT;
            end
            if (int'(clr_idx_q) < BTB_ENTRIES) begin
                btb_val_d[clr_idx_q[BTB_IW-1:0]] = 1'b0;
                btb_off_d[clr_idx_q[BTB_IW-1:0]] = '0;
`ifdef PS_HP_BTB_TAG_EN
                btb_tag_d[clr_idx_q[BTB_IW-1:0]] = '0;
`endif
            end
        end else if (e_upd) begin
            pht_d[e_pht_idx] = e_ctr_nxt;
            bht_d[e_bht_idx] = {e_hist[HIST_LEN-2:0], in_exe_branch_taken};
            // Not-taken branches leave the BTB untouched.
            if (in_exe_branch_taken) begin
                btb_val_d[e_btb_idx] = 1'b1;
                btb_off_d[e_btb_idx] = in_exe_branch_offset;
`ifdef PS_HP_BTB_TAG_EN
                btb_tag_d[e_btb_idx] = in_exe_pc[W-1:BTB_IW+2];
`endif
            end
        end
    end

    // Table storage registers.
    always_ff @(posedge clk) begin
        bht_q     <= bht_d;
        pht_q     <= pht_d;
        btb_val_q <= btb_val_d;
        btb_off_q <= btb_off_d;
`ifdef PS_HP_BTB_TAG_EN
        btb_tag_q <= btb_tag_d;
`endif
    end

endmodule
